instr_refill_ctrl: RTL and testbench

Miss/refill controller for the L1 instruction cache in the instruction memory system. When the fetch address misses in the L1, it stalls the fetch stage, reads the full cache line from main memory word by word over a request/response handshake, and writes each returned word into the cache. It then commits the line by setting tag and valid, and releases the stall. It sits between the fetch stage, the L1 instruction cache fill port and the main-memory read port.

---
 rtl/instr_refill_ctrl.sv | 155 +++++++++++++++
 tb/tb_instr_refill_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_refill_ctrl.sv
// instr_refill_ctrl: miss/refill controller for the L1 instruction cache.
// On a fetch miss it stalls fetch, reads the whole line from main memory one
// word at a time, writes each returned word into the cache fill port, then
// commits the line (tag + valid) and releases the stall.
//
// Handshakes: a memory request transfers on a cycle where mem_req_o and
// mem_ready_i are both high; while mem_req_o is high and mem_ready_i is low,
// mem_addr_o is held stable. Responses (mem_rvalid_i) carry no ready, arrive
// in request order, and are consumed unconditionally on the cycle they are
// valid. fill_wr_o and fill_commit_o are single-cycle strobes with no back
// pressure.
module instr_refill_ctrl #(
  parameter  int LINE_WORDS = 4,
  parameter  int ADDR_WIDTH = 32,
  localparam int WORD_W     = $clog2(LINE_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req_i,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  input  logic                  l1_hit_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ready_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  fill_wr_o,
  output logic [WORD_W-1:0]     fill_word_o,
  output logic [31:0]           fill_data_o,
  output logic [ADDR_WIDTH-1:0] fill_addr_o,
  output logic                  fill_commit_o,
  output logic [2:0]            dbg_state_o
);

  localparam int CNT_W = WORD_W + 1;
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0]      LAST_ISS = CNT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(4 * LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_COMMIT = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] iss_cnt;   // requests accepted by memory
  logic [CNT_W-1:0] ret_cnt;   // responses consumed

  logic                  miss;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] line_base;
  logic                  drain_done;

  // Miss detection, request transfer and line base address.
  always_comb begin
    miss       = fetch_req_i && !l1_hit_i && !flush_i;
    accept     = mem_req_o && mem_ready_i;
    line_base  = fetch_addr_i & ~OFF_MASK;
    drain_done = (ret_cnt + CNT_W'(mem_rvalid_i)) == iss_cnt;
  end

  // Stall rises combinationally in the miss cycle and holds until back in IDLE.
  always_comb begin
    stall_o     = (state != S_IDLE) || miss;
    dbg_state_o = state;
  end

  // Refill FSM with registered request, fill and commit outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      iss_cnt       <= '0;
      ret_cnt       <= '0;
      fill_addr_o   <= '0;
      mem_req_o     <= 1'b0;
      mem_addr_o    <= '0;
      fill_wr_o     <= 1'b0;
      fill_word_o   <= '0;
      fill_data_o   <= '0;
      fill_commit_o <= 1'b0;
    end else begin
      fill_wr_o     <= 1'b0;
      fill_commit_o <= 1'b0;
      case (state)
        S_IDLE: begin
          // Responses arriving here are stale or erroneous and are dropped.
          if (miss) begin
            fill_addr_o <= line_base;
            mem_addr_o  <= line_base;
            mem_req_o   <= 1'b1;
            iss_cnt     <= '0;
            ret_cnt     <= '0;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          // A request accepted in the flush cycle is still outstanding in
          // memory, so it is counted and its response drained later.
          if (accept) begin
            iss_cnt <= iss_cnt + 1'b1;
            if (iss_cnt == LAST_ISS) begin
              mem_req_o <= 1'b0;
            end else begin
              mem_addr_o <= mem_addr_o + WORD_STEP;
            end
          end
          if (flush_i) begin
            mem_req_o <= 1'b0;
            if (mem_rvalid_i) begin
              ret_cnt <= ret_cnt + 1'b1;
            end
            state <= S_DRAIN;
          end else begin
            if (mem_rvalid_i && (ret_cnt != LAST_CNT)) begin
              fill_wr_o   <= 1'b1;
              fill_word_o <= ret_cnt[WORD_W-1:0];
              fill_data_o <= mem_rdata_i;
              ret_cnt     <= ret_cnt + 1'b1;
            end
            if (ret_cnt == LAST_CNT) begin
              // Final word's fill write is on the port this cycle.
              fill_commit_o <= 1'b1;
              state         <= S_COMMIT;
            end else if (accept && (iss_cnt == LAST_ISS)) begin
              state <= S_WAIT;
            end
          end
        end
        S_COMMIT: begin
          // Line is complete; a flush here cannot cancel the commit.
          state <= S_IDLE;
        end
        S_DRAIN: begin
          if (mem_rvalid_i) begin
            ret_cnt <= ret_cnt + 1'b1;
          end
          if (drain_done) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_refill_ctrl.sv
// tb_instr_refill_ctrl: self-checking bench for instr_refill_ctrl.
// A memory model answers accepted requests after a fixed latency; a
// line-level reference (expected address/data per word, expected commit
// cycle) is compared with what the monitor logs from the DUT.
module tb_instr_refill_ctrl;

  localparam int LW = 4;
  localparam int AW = 32;
  localparam int WW = $clog2(LW);

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req_i;
  logic [AW-1:0] fetch_addr_i;
  logic          l1_hit_i;
  logic          flush_i;
  logic          stall_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_ready_i;
  logic          mem_rvalid_i;
  logic [31:0]   mem_rdata_i;
  logic          fill_wr_o;
  logic [WW-1:0] fill_word_o;
  logic [31:0]   fill_data_o;
  logic [AW-1:0] fill_addr_o;
  logic          fill_commit_o;
  logic [2:0]    dbg_state_o;

  always #5 clk = ~clk;

  instr_refill_ctrl #(.LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_req_i  (fetch_req_i),
    .fetch_addr_i (fetch_addr_i),
    .l1_hit_i     (l1_hit_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ready_i  (mem_ready_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .fill_wr_o    (fill_wr_o),
    .fill_word_o  (fill_word_o),
    .fill_data_o  (fill_data_o),
    .fill_addr_o  (fill_addr_o),
    .fill_commit_o(fill_commit_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- scoreboard state ----------------
  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Main-memory contents: a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a_0f0f;
  endfunction

  int          cyc_n;
  int          t0;
  int          mem_lat;
  bit          auto_hit;
  bit          stray_en;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] acc_q[$];
  int          acc_rel[$];
  int          rv_rel[$];
  logic [WW-1:0] fw_q[$];
  logic [31:0] fd_q[$];
  int          fill_rel[$];
  int          commit_cnt;
  int          commit_rel;
  logic [31:0] commit_addr;
  bit          hold_prev;
  logic [31:0] hold_addr;
  logic [31:0] exp_q[$];

  logic          s_stall, s_req, s_fwr, s_commit;
  logic [31:0]   s_addr, s_fdata, s_faddr;
  logic [WW-1:0] s_fword;

  task automatic clear_logs();
    acc_q.delete(); acc_rel.delete(); rv_rel.delete();
    fw_q.delete(); fd_q.delete(); fill_rel.delete(); exp_q.delete();
    commit_cnt  = 0;
    commit_rel  = -1;
    commit_addr = '0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Samples outputs at negedge, updates the memory model, then advances to
  // just after the next posedge and drives the memory response for it.
  task automatic cyc();
    int rel;
    @(negedge clk);
    rel      = cyc_n - t0;
    s_stall  = stall_o;
    s_req    = mem_req_o;
    s_addr   = mem_addr_o;
    s_fwr    = fill_wr_o;
    s_fword  = fill_word_o;
    s_fdata  = fill_data_o;
    s_faddr  = fill_addr_o;
    s_commit = fill_commit_o;
    if (hold_prev) begin
      chk("req_hold", 32'(mem_req_o), 32'd1);
      chk("addr_hold", mem_addr_o, hold_addr);
    end
    hold_prev = mem_req_o && !mem_ready_i && !flush_i && !rst;
    hold_addr = mem_addr_o;
    if (mem_req_o && mem_ready_i) begin
      pend_addr.push_back(mem_addr_o);
      pend_due.push_back(cyc_n + mem_lat);
      acc_q.push_back(mem_addr_o);
      acc_rel.push_back(rel);
    end
    if (mem_rvalid_i) rv_rel.push_back(rel);
    if (fill_wr_o) begin
      fw_q.push_back(fill_word_o);
      fd_q.push_back(fill_data_o);
      fill_rel.push_back(rel);
    end
    if (fill_commit_o) begin
      commit_cnt++;
      commit_rel  = rel;
      commit_addr = fill_addr_o;
    end
    @(posedge clk);
    #1;
    cyc_n++;
    if (auto_hit && s_commit) l1_hit_i = 1'b1;
    if (pend_due.size() > 0 && pend_due[0] == cyc_n) begin
      void'(pend_due.pop_front());
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_word(pend_addr.pop_front());
    end else begin
      mem_rvalid_i = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata_i  = $urandom;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, 32'(s_stall), 32'd0);
    chk({tag, "_req"}, 32'(s_req), 32'd0);
    chk({tag, "_addr"}, s_addr, 32'd0);
    chk({tag, "_fwr"}, 32'(s_fwr), 32'd0);
    chk({tag, "_fword"}, 32'(s_fword), 32'd0);
    chk({tag, "_fdata"}, s_fdata, 32'd0);
    chk({tag, "_faddr"}, s_faddr, 32'd0);
    chk({tag, "_commit"}, 32'(s_commit), 32'd0);
  endtask

  // ---------------- one refill transaction ----------------
  // rmode: 0 ready always, 1 random ready, 2 ready low in cycles 2..4.
  // flush_at/rst_at: relative cycle of a flush / reset pulse (-1 none).
  // force_flush: flush fires regardless and the refill must still commit.
  // extra: if >= 0, exact commit cycle expected = LW+lat+2+extra.
  task automatic run_refill(input logic [31:0] addr, input int lat, input int rmode,
                            input int flush_at, input bit force_flush,
                            input int rst_at, input int extra);
    logic [31:0] base;
    int rel, stall_low, n_exp, last_rv, n_after, lim;
    bit flushed;
    clear_logs();
    base     = addr & ~32'(LW * 4 - 1);
    for (int i = 0; i < LW; i++) exp_q.push_back(base + 32'(4 * i));
    mem_lat  = lat;
    t0       = cyc_n;
    auto_hit = 1'b1;
    stray_en = 1'b0;
    fetch_addr_i = addr;
    fetch_req_i  = 1'b1;
    l1_hit_i     = 1'b0;
    flushed   = 1'b0;
    stall_low = -1;
    for (int k = 0; k < 300 && stall_low < 0; k++) begin
      rel = cyc_n - t0;
      case (rmode)
        0:       mem_ready_i = 1'b1;
        1:       mem_ready_i = ($urandom_range(0, 3) != 0);
        default: mem_ready_i = !(rel >= 2 && rel <= 4);
      endcase
      flush_i = 1'b0;
      rst     = 1'b0;
      if (rel == flush_at && (force_flush || fw_q.size() < LW)) begin
        flush_i = 1'b1;
        flushed = 1'b1;
      end
      if (rel == rst_at) rst = 1'b1;
      cyc();
      if (flushed && !force_flush) fetch_req_i = 1'b0;
      if (rel == rst_at) fetch_req_i = 1'b0;
      if (rel == 0) chk("miss_stall", 32'(s_stall), 32'd1);
      if (rst_at >= 0 && rel == rst_at + 1) chk_zero("after_rst");
      if (rel > 0 && !s_stall) stall_low = rel;
    end
    flush_i     = 1'b0;
    rst         = 1'b0;
    fetch_req_i = 1'b0;
    mem_ready_i = 1'b1;
    chk("refill_done", 32'(stall_low >= 0), 32'd1);
    repeat (lat + 3) cyc();

    // requests are always an in-order prefix of the line, never beyond it
    chk("req_in_line", 32'(acc_q.size() <= LW), 32'd1);
    lim = (acc_q.size() < LW) ? acc_q.size() : LW;
    for (int i = 0; i < lim; i++) chk("req_addr", acc_q[i], exp_q[i]);
    // every fill carries the right word index and memory data
    lim = (fw_q.size() < LW) ? fw_q.size() : LW;
    for (int i = 0; i < lim; i++) begin
      chk("fill_word", 32'(fw_q[i]), 32'(i));
      chk("fill_data", fd_q[i], mem_word(exp_q[i]));
    end

    last_rv = (rv_rel.size() > 0) ? rv_rel[rv_rel.size() - 1] : -1;
    if (rst_at >= 0) begin
      n_exp = 0;
      foreach (rv_rel[i]) if (rv_rel[i] < rst_at) n_exp++;
      chk("rst_fills", 32'(fw_q.size()), 32'(n_exp));
      chk("rst_commit", 32'(commit_cnt), 32'd0);
    end else if (flushed && !force_flush) begin
      n_exp = 0;
      foreach (rv_rel[i]) if (rv_rel[i] < flush_at) n_exp++;
      n_after = 0;
      foreach (acc_rel[i]) if (acc_rel[i] > flush_at) n_after++;
      chk("flush_commit", 32'(commit_cnt), 32'd0);
      chk("flush_fills", 32'(fw_q.size()), 32'(n_exp));
      chk("flush_no_issue", 32'(n_after), 32'd0);
      chk("drain_after_rv", 32'(stall_low > last_rv), 32'd1);
      chk("drain_prompt",
          32'(stall_low <= ((last_rv > flush_at) ? last_rv : flush_at) + 2), 32'd1);
    end else begin
      chk("req_count", 32'(acc_q.size()), 32'(LW));
      chk("fill_count", 32'(fw_q.size()), 32'(LW));
      chk("commit_count", 32'(commit_cnt), 32'd1);
      chk("commit_addr", commit_addr, base);
      if (fill_rel.size() > 0)
        chk("commit_after_fill", 32'(commit_rel), 32'(fill_rel[fill_rel.size() - 1] + 1));
      chk("stall_release", 32'(stall_low), 32'(commit_rel + 1));
      if (extra >= 0) begin
        chk("commit_cycle", 32'(commit_rel), 32'(LW + lat + 2 + extra));
        if (acc_rel.size() > 0) chk("first_req_cycle", 32'(acc_rel[0]), 32'd1);
        if (fill_rel.size() > 0) chk("first_fill_cycle", 32'(fill_rel[0]), 32'(2 + lat));
      end
    end
  endtask

  // ---------------- IDLE decision vectors ----------------
  typedef struct {
    logic fr;
    logic hit;
    logic fl;
    logic exp_stall;
    logic exp_start;
  } vec_t;

  vec_t tbl[6];

  // ---------------- main sequence ----------------
  initial begin
    bit got;
    int fa;
    checks = 0; errors = 0; cyc_n = 0; t0 = 0; mem_lat = 2;
    auto_hit = 1'b0; stray_en = 1'b0; hold_prev = 1'b0;
    rst = 1'b1; fetch_req_i = 1'b0; fetch_addr_i = '0; l1_hit_i = 1'b0;
    flush_i = 1'b0; mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    clear_logs();

    repeat (2) cyc();
    chk_zero("in_rst");
    rst = 1'b0;
    cyc();
    chk_zero("post_rst");

    // single-cycle IDLE decisions: stall and whether a refill starts
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    fetch_addr_i = 32'h0000_1234;
    mem_ready_i  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fetch_req_i = tbl[i].fr;
      l1_hit_i    = tbl[i].hit;
      flush_i     = tbl[i].fl;
      cyc();
      chk("tbl_stall", 32'(s_stall), 32'(tbl[i].exp_stall));
      fetch_req_i = 1'b0;
      flush_i     = 1'b0;
      cyc();
      chk("tbl_start", 32'(s_req), 32'(tbl[i].exp_start));
      if (tbl[i].exp_start) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end
    end

    // hit stream with random flushes and stray responses: nothing happens
    stray_en    = 1'b1;
    fetch_req_i = 1'b1;
    l1_hit_i    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      flush_i      = 1'($urandom_range(0, 1));
      mem_ready_i  = 1'($urandom_range(0, 1));
      fetch_addr_i = $urandom & ~32'd3;
      cyc();
      chk("hit_quiet", {28'd0, s_stall, s_req, s_fwr, s_commit}, 32'd0);
    end
    stray_en = 1'b0;
    flush_i  = 1'b0;
    cyc();

    // directed refills
    run_refill(32'h0000_1234, 2, 0, -1, 1'b0, -1, 0);
    run_refill(32'h0000_1234, 2, 2, -1, 1'b0, -1, 3);
    run_refill(32'h0000_1234, 2, 0, 2, 1'b0, -1, -1);
    chk("flush_req_count", 32'(acc_q.size()), 32'd2);
    run_refill(32'h0000_1234, 2, 0, 8, 1'b1, -1, 0);
    run_refill(32'h0000_1234, 2, 0, -1, 1'b0, 5, -1);
    run_refill(32'h0000_1234, 2, 0, -1, 1'b0, -1, 0);

    // back-to-back: a new miss right after commit starts without a gap
    clear_logs();
    mem_lat = 2; t0 = cyc_n; auto_hit = 1'b0; mem_ready_i = 1'b1;
    fetch_addr_i = 32'h0000_2000; fetch_req_i = 1'b1; l1_hit_i = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      cyc();
      if (s_commit) got = 1'b1;
    end
    chk("b2b_commit", 32'(got), 32'd1);
    fetch_addr_i = 32'h0000_3008;
    cyc();
    chk("b2b_stall", 32'(s_stall), 32'd1);
    cyc();
    chk("b2b_req", 32'(s_req), 32'd1);
    chk("b2b_addr", s_addr, 32'h0000_3000);
    rst = 1'b1; fetch_req_i = 1'b0;
    cyc();
    rst = 1'b0;
    repeat (6) cyc();
    auto_hit = 1'b1;

    // randomized refills, some with flushes at random points
    for (int i = 0; i < 24; i++) begin
      fa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14)) : -1;
      run_refill($urandom & ~32'd3, int'($urandom_range(1, 4)), 1, fa, 1'b0, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
